audio_i2s_tx: RTL
=================

# audio_i2s_tx

Serial output stage that sits directly downstream of the audio controller. It takes the controller's parallel 16-bit left/right samples and shifts them out as a standard I2S stream (BCLK, LRCK, SDATA) to an external DAC/codec. It also generates the sample clock that the controller uses to advance to its next sample, so it sets the playback rate for the whole audio path.

## Interface
Parameters:
- BCLK_HALF, 17: system clocks per BCLK half-period. Must be ≥ 2; a value below 2 is a fatal elaboration error. Sample rate = clock / (128·BCLK_HALF).

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset (0 = reset).
- i_enable  in  1  run request; sampled only at frame boundaries and when idle.
- i_sample_left  in  16  signed PCM left sample from the controller.
- i_sample_right  in  16  signed PCM right sample from the controller.
- o_sample_clock  out  1  square wave at the sample rate, fed to the controller's output sample clock input. High during the left half-frame.
- o_i2s_bclk  out  1  bit clock.
- o_i2s_lrck  out  1  word select: 0 = left, 1 = right.
- o_i2s_sdata  out  1  serial data.
- o_busy  out  1  1 while in RUN.

## Operation
- Two-state FSM:
  - IDLE:
    - All outputs 0.
    - When i_enable = 1, enter RUN on the next clock.
  - RUN, on entry:
    - div = 0, bclk = 0, p = 0.
    - Both input samples latched into shadow registers.
    - lrck = 0, o_sample_clock = 1, sdata = 0.
- Divider in RUN:
  - div counts 0..BCLK_HALF-1. At the wrap, bclk toggles.
  - On each bclk 1→0 toggle (falling edge), frame position p (6 bits) increments mod 64, and lrck, sdata and o_sample_clock update.
- Frame mapping:
  - lrck = p[5]; o_sample_clock = ~p[5].
  - Slot bit s = p[4:0].
  - sdata = shadow_ch[16-s] for 1 ≤ s ≤ 16, where ch = left if p[5] = 0, else right. The MSB is at s = 1 (standard I2S one-bit delay); the LSB is at s = 16.
  - sdata = 0 for s = 0 and for 17..31.
- Sample latch: on the falling edge where p wraps 63→0, both shadows are loaded from the inputs.
  - The latch happens on the same clock that o_sample_clock rises.
  - So a frame carries the values that were present before that rising edge. The controller's post-edge update lands in the next frame.
- Disable:
  - i_enable is checked only at the 63→0 wrap.
  - If i_enable = 0 at the wrap, the FSM goes to IDLE instead of wrapping. All outputs are 0 on the next clock.
  - Deasserting i_enable mid-frame therefore always completes the current frame.
- Reset (i_reset = 0), at any time including mid-frame: immediately forces IDLE, all counters to 0, shadows to 0 and all outputs to 0.

## Timing
- All outputs are registered; no combinational path from input to output.
- Enable to first activity: 1 clock from i_enable = 1 (in IDLE) to o_busy = 1 and o_sample_clock = 1.
- BCLK period = 2·BCLK_HALF clocks. The first rising BCLK edge comes BCLK_HALF clocks after RUN entry.
- Frame length = 64 BCLK = 128·BCLK_HALF clocks. o_sample_clock has a 50 % duty cycle.
- lrck, sdata and o_sample_clock change only on the same clock as a BCLK falling edge, so the DAC samples them on the BCLK rising edge.

## Structure
- Package audio_i2s_pkg holds:
  - FRAME_BITS = 64, SLOT_BITS = 32, SAMPLE_BITS = 16.
  - The FSM state enum (IDLE, RUN).
- One sub-module, audio_i2s_clkgen: the BCLK_HALF divider. It outputs bclk plus one-clock fall/rise strobes and has a synchronous clear used at RUN entry.
- The top level holds the FSM, p counter, shadows and data mux.

## Test plan
- Reset values:
  - Hold i_reset = 0 with i_enable = 1 → all outputs 0.
  - Release reset → o_busy = 1 after 1 clock.
- Bit pattern (BCLK_HALF = 2, L = 16'hA5F0, R = 16'h0F5A):
  - Capture sdata on 64 BCLK rising edges.
  - Required: bit 0 = 0, bits 1..16 = A5F0 MSB-first, bits 17..32 = 0, bits 33..48 = 0F5A, bits 49..63 = 0.
  - lrck = 1 exactly on bits 32..63.
- Latch timing:
  - Change L from 16'h1234 to 16'h5678 one clock after o_sample_clock rises.
  - Required: current frame shows 1234, next frame shows 5678.
- Disable mid-frame:
  - Drop i_enable at p = 10.
  - Required: frame runs to p = 63, then all outputs are 0 and o_busy = 0 on the next clock. Total = 128·BCLK_HALF clocks from RUN entry.
- Async reset at p = 40, between clock edges:
  - Required: outputs go to 0 without waiting for a clock edge.
  - After release, a new frame starts at p = 0 with fresh latched samples.
- Rate check at BCLK_HALF = 17 with a 100 MHz clock:
  - o_sample_clock period = 2176 clocks.
  - BCLK period = 34 clocks.

Source files
------------

// File: rtl/audio_i2s_pkg.sv
// Shared constants, FSM state type and the slot-to-sample bit mapping for the I2S transmitter.
package audio_i2s_pkg;

  localparam int FRAME_BITS  = 64;
  localparam int SLOT_BITS   = 32;
  localparam int SAMPLE_BITS = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Slot 1 carries the MSB (one-bit I2S delay), slot 16 the LSB, everything else is 0.
  function automatic logic sample_bit(input logic [SAMPLE_BITS-1:0] w, input logic [4:0] s);
    logic b;
    b = 1'b0;
    for (int i = 1; i <= SAMPLE_BITS; i++) begin
      if (s == 5'(i)) b = w[SAMPLE_BITS-i];
    end
    return b;
  endfunction

endpackage

// File: rtl/audio_i2s_clkgen.sv
// BCLK divider: toggles bclk every BCLK_HALF clocks, with strobes flagging the clock on which it falls/rises.
module audio_i2s_clkgen #(
  parameter int BCLK_HALF = 17
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_bclk,
  output logic o_fall,
  output logic o_rise
);

  localparam int DW = $clog2(BCLK_HALF);

  logic [DW-1:0] div_q;
  logic          bclk_q;
  logic          wrap;

  // Strobes are asserted during the cycle whose closing edge moves bclk, so
  // downstream registers update on the same edge as the bclk transition.
  assign wrap   = i_run && (div_q == DW'(BCLK_HALF - 1));
  assign o_fall = wrap && bclk_q;
  assign o_rise = wrap && !bclk_q;
  assign o_bclk = bclk_q;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else if (i_clear) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else if (i_run) begin
      if (wrap) begin
        div_q  <= '0;
        bclk_q <= ~bclk_q;
      end else begin
        div_q <= div_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S serializer: frames two 16-bit samples per 64-BCLK frame and generates the controller sample clock.
module audio_i2s_tx
  import audio_i2s_pkg::*;
#(
  parameter int BCLK_HALF = 17
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [15:0] i_sample_left,
  input  logic [15:0] i_sample_right,
  output logic        o_sample_clock,
  output logic        o_i2s_bclk,
  output logic        o_i2s_lrck,
  output logic        o_i2s_sdata,
  output logic        o_busy
);

  if (BCLK_HALF < 2) begin : g_bad_bclk_half
    $fatal(1, "audio_i2s_tx: BCLK_HALF must be >= 2");
  end

  state_e                 state_q;
  logic [5:0]             p_q;
  logic [SAMPLE_BITS-1:0] shl_q, shr_q;
  logic                   lrck_q, sclk_q, sdata_q;

  logic                   bclk, bclk_fall, unused_bclk_rise;
  logic [5:0]             p_nxt;
  logic                   right_nxt, frame_end;
  logic [SAMPLE_BITS-1:0] word_nxt;

  audio_i2s_clkgen #(.BCLK_HALF(BCLK_HALF)) u_clkgen (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_clear (state_q == IDLE),
    .i_run   (state_q == RUN),
    .o_bclk  (bclk),
    .o_fall  (bclk_fall),
    .o_rise  (unused_bclk_rise)
  );

  assign p_nxt     = p_q + 6'd1;
  assign right_nxt = (p_nxt >= 6'(SLOT_BITS));
  assign word_nxt  = right_nxt ? shr_q : shl_q;
  assign frame_end = (p_q == 6'(FRAME_BITS - 1));

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      shl_q   <= '0;
      shr_q   <= '0;
      lrck_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_enable) begin
            state_q <= RUN;
            p_q     <= '0;
            shl_q   <= i_sample_left;
            shr_q   <= i_sample_right;
            lrck_q  <= 1'b0;
            sclk_q  <= 1'b1;
            sdata_q <= 1'b0;
          end
        end
        RUN: begin
          if (bclk_fall) begin
            p_q     <= p_nxt;
            lrck_q  <= right_nxt;
            sclk_q  <= ~right_nxt;
            sdata_q <= sample_bit(word_nxt, p_nxt[4:0]);
            // Frame boundary: the only place enable is honoured and samples are taken.
            if (frame_end) begin
              if (i_enable) begin
                shl_q <= i_sample_left;
                shr_q <= i_sample_right;
              end else begin
                state_q <= IDLE;
                p_q     <= '0;
                lrck_q  <= 1'b0;
                sclk_q  <= 1'b0;
                sdata_q <= 1'b0;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_busy         = (state_q == RUN);
  assign o_sample_clock = sclk_q;
  assign o_i2s_bclk     = bclk;
  assign o_i2s_lrck     = lrck_q;
  assign o_i2s_sdata    = sdata_q;

endmodule
